muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution stage.
- Consumes the two register-file read operands (RD1/RD2 values) and produces a write-back request (address, data, enable) that drives the register file write port (A3/WD3/WE3).
- Performs multi-cycle operations and signals completion with a simple start/busy/done handshake, so the core can stall until the result is ready.

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide stage: one radix-2 step per cycle.
// It produces a register-file write-back request (RESULT / RESULT_ADDR / WE).
//
// state  | meaning
// S_IDLE | waiting for START; divide-by-zero and signed overflow resolve here
// S_CALC | one shift-add (multiply) or restoring-subtract (divide) step per cycle
// S_DONE | single-cycle result pulse; WE asserted unless the destination is x0
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic [2:0]            FUNCT3,
   input  logic [DATA_WIDTH-1:0] RS1_VAL,
   input  logic [DATA_WIDTH-1:0] RS2_VAL,
   input  logic [ADDR_WIDTH-1:0] RD_ADDR,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [DATA_WIDTH-1:0] RESULT,
   output logic [ADDR_WIDTH-1:0] RESULT_ADDR,
   output logic                  WE
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [W-1:0]          op_q, op_d;
   logic [2*W-1:0]        acc_q, acc_d;
   logic                  neg_q, neg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          result_q, result_d;
   logic [ADDR_WIDTH-1:0] result_addr_q, result_addr_d;

   logic [W-1:0]   min_neg;
   logic           is_div_in, sa_in, sb_in, div_zero, div_ovf;
   logic [W-1:0]   mag_a_in, mag_b_in;
   logic [W:0]     mul_sum, div_shift;
   logic           div_ge;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] mul_next, div_next, calc_next, prod_s;
   logic [W-1:0]   quo_s, rem_s, final_res;

   assign min_neg = {1'b1, {(W-1){1'b0}}};

   // Operand decode for a new request; signedness depends on the op.
   assign is_div_in = FUNCT3[2];
   assign sa_in     = RS1_VAL[W-1] & (is_div_in ? ~FUNCT3[0] : (FUNCT3 != 3'b011));
   assign sb_in     = RS2_VAL[W-1] & (is_div_in ? ~FUNCT3[0] : ~FUNCT3[1]);
   assign mag_a_in  = sa_in ? -RS1_VAL : RS1_VAL;
   assign mag_b_in  = sb_in ? -RS2_VAL : RS2_VAL;
   assign div_zero  = is_div_in && (RS2_VAL == '0);
   assign div_ovf   = is_div_in && !FUNCT3[0] && (RS1_VAL == min_neg) && (RS2_VAL == '1);

   // acc holds {partial product, multiplier} or {remainder, dividend->quotient}.
   assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, op_q} : '0);
   assign mul_next  = {mul_sum, acc_q[W-1:1]};
   assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
   assign div_ge    = div_shift >= {1'b0, op_q};
   assign div_rem   = div_ge ? W'(div_shift - {1'b0, op_q}) : div_shift[W-1:0];
   assign div_next  = {div_rem, acc_q[W-2:0], div_ge};
   assign calc_next = funct3_q[2] ? div_next : mul_next;

   assign prod_s = neg_q ? -calc_next : calc_next;
   assign quo_s  = neg_q ? -calc_next[W-1:0] : calc_next[W-1:0];
   assign rem_s  = neg_q ? -calc_next[2*W-1:W] : calc_next[2*W-1:W];

   always_comb begin
      final_res = rem_s;
      case (funct3_q)
         3'b000:                 final_res = prod_s[W-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_s[2*W-1:W];
         3'b100, 3'b101:         final_res = quo_s;
         default:                final_res = rem_s;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      funct3_d      = funct3_q;
      op_d          = op_q;
      acc_d         = acc_q;
      neg_d         = neg_q;
      cnt_d         = cnt_q;
      result_d      = result_q;
      result_addr_d = result_addr_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               funct3_d      = FUNCT3;
               result_addr_d = RD_ADDR;
               cnt_d         = '0;
               if (div_zero) begin
                  result_d = FUNCT3[1] ? RS1_VAL : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = FUNCT3[1] ? '0 : min_neg;
                  state_d  = S_DONE;
               end else begin
                  op_d    = is_div_in ? mag_b_in : mag_a_in;
                  acc_d   = {{W{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
                  neg_d   = (is_div_in && FUNCT3[1]) ? sa_in : (sa_in ^ sb_in);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            acc_d = calc_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               result_d = final_res;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= S_IDLE;
         funct3_q      <= '0;
         op_q          <= '0;
         acc_q         <= '0;
         neg_q         <= 1'b0;
         cnt_q         <= '0;
         result_q      <= '0;
         result_addr_q <= '0;
      end else begin
         state_q       <= state_d;
         funct3_q      <= funct3_d;
         op_q          <= op_d;
         acc_q         <= acc_d;
         neg_q         <= neg_d;
         cnt_q         <= cnt_d;
         result_q      <= result_d;
         result_addr_q <= result_addr_d;
      end
   end

   assign BUSY        = (state_q != S_IDLE);
   assign DONE        = (state_q == S_DONE);
   assign WE          = DONE && (result_addr_q != '0);
   assign RESULT      = result_q;
   assign RESULT_ADDR = result_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected write-backs,
// and a monitor pops and compares them whenever DONE is seen.
module tb_muldiv_unit;

   localparam int W = 32;
   localparam logic [31:0] MIN = 32'h8000_0000;

   logic        CLK, RST_N, START;
   logic [2:0]  FUNCT3;
   logic [31:0] RS1_VAL, RS2_VAL;
   logic [4:0]  RD_ADDR;
   logic        BUSY, DONE, WE;
   logic [31:0] RESULT;
   logic [4:0]  RESULT_ADDR;

   muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .FUNCT3(FUNCT3),
      .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .RD_ADDR(RD_ADDR),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
      .RESULT_ADDR(RESULT_ADDR), .WE(WE)
   );

   typedef struct {
      logic [31:0] res;
      logic [4:0]  addr;
      logic        we;
      int          lat;
      int          start_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] last_res = '0;
   logic        busy_chk_pending = 1'b0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Arithmetic reference: 64-bit products, native signed/unsigned division.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && ((b == 0) || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF));
   endfunction

   // Latency counts edges from the START edge (inclusive) to the edge opening the DONE cycle.
   always @(negedge CLK) begin
      exp_t e;
      if (busy_chk_pending) begin
         chk("busy_after_done", BUSY, 0);
         busy_chk_pending = 1'b0;
      end
      if (DONE) begin
         chk("done_expected", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("result", RESULT, e.res);
            chk("result_addr", RESULT_ADDR, e.addr);
            chk("we", WE, e.we);
            chk("latency", cyc - e.start_cyc + 1, e.lat);
            last_res = e.res;
            busy_chk_pending = 1'b1;
         end
      end
   end

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      exp_t e;
      @(negedge CLK);
      FUNCT3 = f3; RS1_VAL = a; RS2_VAL = b; RD_ADDR = rd; START = 1'b1;
      e.res = ref_model(f3, a, b);
      e.addr = rd;
      e.we = (rd != 0);
      e.lat = is_fast(f3, a, b) ? 1 : W + 1;
      e.start_cyc = cyc + 1;
      sb_q.push_back(e);
      @(negedge CLK);
      START = 1'b0;
      chk("busy_rise", BUSY, 1);
      FUNCT3 = 3'($urandom); RS1_VAL = $urandom; RS2_VAL = $urandom; RD_ADDR = 5'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (!BUSY) break;
      end
      chk("idle_reached", BUSY, 0);
      chk("result_held", RESULT, last_res);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return MIN;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      RST_N = 1'b0; START = 1'b0; FUNCT3 = '0; RS1_VAL = '0; RS2_VAL = '0; RD_ADDR = '0;
      #1;
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_we", WE, 0);
      chk("rst_result", RESULT, 0);
      chk("rst_result_addr", RESULT_ADDR, 0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;

      issue(3'd0, 32'd7, 32'd6, 5'd5);                    wait_idle();
      issue(3'd1, MIN, MIN, 5'd1);                        wait_idle();
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);    wait_idle();
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);    wait_idle();
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);            wait_idle();
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);            wait_idle();
      issue(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7);            wait_idle();
      issue(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8);            wait_idle();
      issue(3'd5, 32'd100, 32'd0, 5'd9);                  wait_idle();
      issue(3'd6, 32'd100, 32'd0, 5'd10);                 wait_idle();
      issue(3'd4, MIN, 32'hFFFF_FFFF, 5'd11);             wait_idle();
      issue(3'd6, MIN, 32'hFFFF_FFFF, 5'd12);             wait_idle();

      // x0 destination plus a START pulse while the op is still iterating
      issue(3'd0, 32'd3, 32'd3, 5'd0);
      repeat (10) @(negedge CLK);
      FUNCT3 = 3'd4; RS1_VAL = 32'd1000; RS2_VAL = 32'd3; RD_ADDR = 5'd9; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_idle();

      // asynchronous reset in the middle of a divide
      issue(3'd4, 32'd12345, 32'd7, 5'd13);
      repeat (10) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("abort_busy", BUSY, 0);
      chk("abort_done", DONE, 0);
      chk("abort_we", WE, 0);
      chk("abort_result", RESULT, 0);
      sb_q.delete(sb_q.size() - 1);
      last_res = '0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (40) @(negedge CLK);
      chk("abort_no_done_busy", BUSY, 0);
      issue(3'd4, 32'hFFFF_FF00, 32'd7, 5'd14);           wait_idle();

      for (int n = 0; n < 200; n++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
         wait_idle();
      end

      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
